// File: rtl/ifetch_unit.sv
// ifetch_unit - instruction-fetch stage feeding the main decoder.
//
// Holds the PC and fetches one instruction at a time over a req/ack
// instruction-memory port. The instruction is presented to decode, and then
// the PC is stepped according to decode's npc_op. Fetches do not overlap:
// the next request starts only after decode accepts the current instruction.
//
// Optional feature macro: IFETCH_JR_EN
//   defined   : npc_op=11 jumps to {jr_target[31:2],2'b00}
//   undefined : jr_target is unused and npc_op=11 behaves as PLUS4
//
// Parameters
//   RESET_PC       PC loaded on reset (word aligned)
//   FETCH_TIMEOUT  S_REQ cycles without im_ack before error; 0 disables
//
// Ports
//   clk        clock, all state on rising edge
//   rstn       asynchronous active-low reset
//   im_req     fetch request to instruction memory
//   im_addr    fetch address (= pc), stable while im_req
//   im_ack     memory returns im_rdata this cycle
//   im_rdata   fetched instruction word
//   ir_valid   instr/pc_out valid for decode
//   ir_ready   decode consumes instr this cycle (npc_op/imm26 valid with it)
//   instr      instruction register
//   pc_out     PC of instr
//   pc_plus4   pc_out+4 (jal link value)
//   npc_op     00 PLUS4, 01 BRANCH (taken), 10 JUMP, 11 JUMPR
//   imm26      instr[25:0] from decode; branch uses imm26[15:0]
//   jr_target  rs value for JUMPR
//   fetch_err  sticky fetch-timeout flag
module ifetch_unit #(
   parameter logic [31:0] RESET_PC      = 32'h0000_3000,
   parameter int unsigned FETCH_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rstn,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_ack,
   input  logic [31:0] im_rdata,
   output logic        ir_valid,
   input  logic        ir_ready,
   output logic [31:0] instr,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   input  logic [1:0]  npc_op,
   input  logic [25:0] imm26,
   input  logic [31:0] jr_target,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_VALID,
      S_ERR
   } state_t;

   // The counter only has to reach FETCH_TIMEOUT-1.
   localparam int unsigned CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

   state_t           state, state_nxt;
   logic [31:0]      pc, pc_nxt;
   logic [31:0]      instr_q, instr_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [31:0]      pc4;
   logic [31:0]      br_off;
   logic [31:0]      npc;
   logic             unused_jr_bits;

   assign pc4    = pc + 32'd4;
   assign br_off = {{14{imm26[15]}}, imm26[15:0], 2'b00};

`ifdef IFETCH_JR_EN
   assign unused_jr_bits = ^jr_target[1:0];
`else
   assign unused_jr_bits = ^jr_target;
`endif

   always_comb begin
      npc = pc4;
      case (npc_op)
         2'b00: npc = pc4;
         2'b01: npc = pc4 + br_off;
         2'b10: npc = {pc4[31:28], imm26, 2'b00};
`ifdef IFETCH_JR_EN
         2'b11: npc = {jr_target[31:2], 2'b00};
`else
         2'b11: npc = pc4;
`endif
         default: npc = pc4;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= S_IDLE;
         pc      <= RESET_PC;
         instr_q <= '0;
         cnt     <= '0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         instr_q <= instr_nxt;
         cnt     <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      instr_nxt = instr_q;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: state_nxt = S_REQ;
         S_REQ: begin
            // ack is checked first so it wins over a coincident timeout
            if (im_ack) begin
               instr_nxt = im_rdata;
               cnt_nxt   = '0;
               state_nxt = S_VALID;
            end else if (FETCH_TIMEOUT != 0 && cnt == CNT_LAST) begin
               state_nxt = S_ERR;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_VALID: begin
            if (ir_ready) begin
               pc_nxt    = npc;
               state_nxt = S_REQ;
            end
         end
         default: state_nxt = S_ERR;
      endcase
   end

   assign im_req    = (state == S_REQ);
   assign ir_valid  = (state == S_VALID);
   assign fetch_err = (state == S_ERR);
   assign im_addr   = pc;
   assign pc_out    = pc;
   assign pc_plus4  = pc4;
   assign instr     = instr_q;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rstn;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ack;
   logic [31:0] im_rdata;
   logic        ir_valid;
   logic        ir_ready;
   logic [31:0] instr;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic [1:0]  npc_op;
   logic [25:0] imm26;
   logic [31:0] jr_target;
   logic        fetch_err;

   // second instance used only for the 32-bit wrap case
   logic        w_rstn;
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_ack;
   logic [31:0] w_rdata;
   logic        w_valid;
   logic        w_ready;
   logic [31:0] w_instr;
   logic [31:0] w_pc;
   logic [31:0] w_pc4;
   logic [1:0]  w_op;
   logic [25:0] w_imm;
   logic [31:0] w_jr;
   logic        w_err;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   always #5 clk = ~clk;

   ifetch_unit #(.RESET_PC(32'h0000_3000), .FETCH_TIMEOUT(4)) dut (
      .clk(clk), .rstn(rstn),
      .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
      .ir_valid(ir_valid), .ir_ready(ir_ready), .instr(instr),
      .pc_out(pc_out), .pc_plus4(pc_plus4),
      .npc_op(npc_op), .imm26(imm26), .jr_target(jr_target),
      .fetch_err(fetch_err)
   );

   ifetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FETCH_TIMEOUT(4)) dut_wrap (
      .clk(clk), .rstn(w_rstn),
      .im_req(w_req), .im_addr(w_addr), .im_ack(w_ack), .im_rdata(w_rdata),
      .ir_valid(w_valid), .ir_ready(w_ready), .instr(w_instr),
      .pc_out(w_pc), .pc_plus4(w_pc4),
      .npc_op(w_op), .imm26(w_imm), .jr_target(w_jr),
      .fetch_err(w_err)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] rdata;
      int unsigned delay;
      logic [1:0]  op;
      logic [25:0] imm;
      logic [31:0] jr;
      logic [31:0] next_pc;
   } vec_t;

   vec_t vecs[8];

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic do_fetch(input vec_t v, input int unsigned k);
      int unsigned w;
      w = 0;
      while (im_req !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk1($sformatf("v%0d req_seen", k), im_req, 1'b1);
      chk32($sformatf("v%0d im_addr", k), im_addr, v.pc);
      for (int unsigned d = 0; d < v.delay; d++) begin
         im_ack   = 1'b0;
         im_rdata = 32'hBAD0_0000 + d;
         @(negedge clk);
         chk1($sformatf("v%0d req_hold%0d", k, d), im_req, 1'b1);
         chk32($sformatf("v%0d addr_hold%0d", k, d), im_addr, v.pc);
      end
      im_ack   = 1'b1;
      im_rdata = v.rdata;
      @(negedge clk);
      // spurious ack and junk decode inputs while holding ir_ready low
      im_ack    = 1'b1;
      im_rdata  = ~v.rdata;
      ir_ready  = 1'b0;
      npc_op    = 2'b10;
      imm26     = 26'h155_5555;
      jr_target = 32'hFFFF_FFFF;
      chk1($sformatf("v%0d ir_valid", k), ir_valid, 1'b1);
      chk1($sformatf("v%0d req_low", k), im_req, 1'b0);
      chk32($sformatf("v%0d instr", k), instr, v.rdata);
      chk32($sformatf("v%0d pc_out", k), pc_out, v.pc);
      chk32($sformatf("v%0d pc_plus4", k), pc_plus4, v.pc + 32'd4);
      @(negedge clk);
      im_ack = 1'b0;
      chk32($sformatf("v%0d instr_held", k), instr, v.rdata);
      chk1($sformatf("v%0d valid_held", k), ir_valid, 1'b1);
      ir_ready  = 1'b1;
      npc_op    = v.op;
      imm26     = v.imm;
      jr_target = v.jr;
      @(negedge clk);
      ir_ready  = 1'b0;
      npc_op    = 2'b01;
      imm26     = '1;
      jr_target = '0;
      chk1($sformatf("v%0d valid_drop", k), ir_valid, 1'b0);
      chk1($sformatf("v%0d next_req", k), im_req, 1'b1);
      chk32($sformatf("v%0d next_addr", k), im_addr, v.next_pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] jr_next;
`ifdef IFETCH_JR_EN
      jr_next = 32'h0000_3100;
`else
      jr_next = 32'h0000_3044;
`endif
      vecs[0] = '{32'h0000_3000, 32'h8C01_0000, 0, 2'b00, 26'h0000000, 32'h0, 32'h0000_3004};
      vecs[1] = '{32'h0000_3004, 32'h2001_0005, 1, 2'b00, 26'h3FFFFFF, 32'h0, 32'h0000_3008};
      vecs[2] = '{32'h0000_3008, 32'h1000_FFFF, 2, 2'b01, 26'h3FFFFFF, 32'h0, 32'h0000_3008};
      vecs[3] = '{32'h0000_3008, 32'h1000_0003, 0, 2'b01, 26'h2AA0003, 32'h0, 32'h0000_3018};
      vecs[4] = '{32'h0000_3018, 32'h0800_0C04, 3, 2'b10, 26'h0000C04, 32'h0, 32'h0000_3010};
      vecs[5] = '{32'h0000_3010, 32'h0800_0C10, 0, 2'b10, 26'h0000C10, 32'h0, 32'h0000_3040};
      vecs[6] = '{32'h0000_3040, 32'h03E0_0008, 1, 2'b11, 26'h0000005, 32'h0000_3103, jr_next};
      vecs[7] = '{jr_next,       32'h0800_0C00, 0, 2'b10, 26'h0000C00, 32'h0, 32'h0000_3000};

      rstn = 1'b0; im_ack = 1'b0; im_rdata = '0; ir_ready = 1'b0;
      npc_op = 2'b00; imm26 = '0; jr_target = '0;
      w_rstn = 1'b0; w_ack = 1'b1; w_rdata = 32'h1234_5678; w_ready = 1'b1;
      w_op = 2'b00; w_imm = '0; w_jr = '0;

      repeat (2) @(negedge clk);
      chk1("rst im_req", im_req, 1'b0);
      chk1("rst ir_valid", ir_valid, 1'b0);
      chk1("rst fetch_err", fetch_err, 1'b0);
      chk32("rst instr", instr, 32'h0);
      chk32("rst pc_out", pc_out, 32'h0000_3000);
      rstn = 1'b1;
      @(negedge clk);

      for (int unsigned i = 0; i < 8; i++) do_fetch(vecs[i], i);

      // timeout: four request cycles without ack
      im_ack = 1'b0;
      for (int unsigned j = 0; j < 3; j++) begin
         @(negedge clk);
         chk1($sformatf("to req%0d", j), im_req, 1'b1);
         chk1($sformatf("to err%0d", j), fetch_err, 1'b0);
      end
      @(negedge clk);
      chk1("to fetch_err", fetch_err, 1'b1);
      chk1("to im_req", im_req, 1'b0);
      chk1("to ir_valid", ir_valid, 1'b0);
      im_ack = 1'b1; ir_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk1("err sticky", fetch_err, 1'b1);
      chk1("err no req", im_req, 1'b0);
      chk1("err no valid", ir_valid, 1'b0);
      im_ack = 1'b0; ir_ready = 1'b0;

      // reset mid-request with a late ack landing in S_IDLE
      rstn = 1'b0;
      #1;
      chk1("rst2 err clr", fetch_err, 1'b0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk1("mid req", im_req, 1'b1);
      chk32("mid addr", im_addr, 32'h0000_3000);
      rstn = 1'b0;
      #1;
      chk1("mid req async drop", im_req, 1'b0);
      im_ack = 1'b1; im_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      im_ack = 1'b0;
      chk1("late ack valid", ir_valid, 1'b0);
      chk1("late ack req", im_req, 1'b1);
      chk32("late ack instr", instr, 32'h0);
      chk32("late ack addr", im_addr, 32'h0000_3000);
      do_fetch(vecs[0], 100);

      // 32-bit wrap of pc+4
      w_rstn = 1'b1;
      @(negedge clk);
      chk1("wrap req", w_req, 1'b1);
      chk32("wrap addr", w_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      chk1("wrap valid", w_valid, 1'b1);
      chk32("wrap pc_plus4", w_pc4, 32'h0000_0000);
      chk32("wrap instr", w_instr, 32'h1234_5678);
      @(negedge clk);
      chk1("wrap next req", w_req, 1'b1);
      chk32("wrap next addr", w_addr, 32'h0000_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
